fifo_wr_arbiter: RTL and testbench

Round-robin write-port arbiter that shares the single fifo write port (data_in/wr_en/full) among NUM_REQ producers.
- Each producer uses a valid/ready handshake.
- Accepted beats go through a one-entry output holding register; the block drives wr_en only when fifo full is low.
- Sits between the producer agents and the fifo DUT, clocked by the same clk/rst as the fifo.

---
 rtl/fifo_arb_pkg.sv | 40 ++++
 rtl/fifo_wr_arbiter_rr_pick_core.sv | 43 ++++
 rtl/fifo_wr_arbiter.sv | 157 +++++++++++++++
 tb/tb_fifo_wr_arbiter.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/fifo_arb_pkg.sv
// Shared types and defaults for the fifo write-port arbiter.
// Includes a reference round-robin pick helper for up to 8 requesters.
package fifo_arb_pkg;

   localparam int unsigned NUM_REQ_DEF    = 4;
   localparam int unsigned DATA_WIDTH_DEF = 8;
   localparam int unsigned NUM_REQ_MAX    = 8;
   localparam int unsigned PTR_W_MAX      = 3;

   typedef enum logic {ARB_IDLE, ARB_LOCKED} arb_state_t;

   typedef struct packed {
      logic                 found;
      logic [PTR_W_MAX-1:0] idx;
   } rr_pick_t;

   // First asserted bit at or above ptr, otherwise first asserted bit overall.
   function automatic rr_pick_t rr_pick(input logic [NUM_REQ_MAX-1:0] valid,
                                        input logic [PTR_W_MAX-1:0]   ptr);
      rr_pick_t r;
      logic     hit_hi;
      r      = '0;
      hit_hi = 1'b0;
      for (int unsigned i = 0; i < NUM_REQ_MAX; i++) begin
         if (valid[i] && (i >= 32'(ptr)) && !hit_hi) begin
            hit_hi  = 1'b1;
            r.found = 1'b1;
            r.idx   = PTR_W_MAX'(i);
         end
      end
      for (int unsigned i = 0; i < NUM_REQ_MAX; i++) begin
         if (valid[i] && !r.found) begin
            r.found = 1'b1;
            r.idx   = PTR_W_MAX'(i);
         end
      end
      return r;
   endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick_core.sv
// Combinational round-robin pick: masked priority encoder (index >= ptr)
// with an unmasked fallback when nothing at or above ptr is valid.
module rr_pick_core
   import fifo_arb_pkg::*;
#(
   parameter int unsigned NUM_REQ = NUM_REQ_DEF
) (
   input  logic [NUM_REQ-1:0]         valid_i,
   input  logic [$clog2(NUM_REQ)-1:0] ptr_i,
   output logic [$clog2(NUM_REQ)-1:0] idx_o,
   output logic                       found_o
);

   localparam int unsigned PTR_W = $clog2(NUM_REQ);

   logic [NUM_REQ-1:0] masked;
   logic [PTR_W-1:0]   idx_hi, idx_any;
   logic               found_hi, found_any;

   always_comb begin
      masked    = '0;
      idx_hi    = '0;
      idx_any   = '0;
      found_hi  = 1'b0;
      found_any = 1'b0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         masked[i] = valid_i[i] & (i >= 32'(ptr_i));
      end
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         if (masked[i] && !found_hi) begin
            found_hi = 1'b1;
            idx_hi   = PTR_W'(i);
         end
         if (valid_i[i] && !found_any) begin
            found_any = 1'b1;
            idx_any   = PTR_W'(i);
         end
      end
      idx_o   = found_hi ? idx_hi : idx_any;
      found_o = found_any;
   end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one fifo write port among NUM_REQ producers.
// Define FIFO_ARB_BURST_EN to compile in burst lock (up to MAX_BURST beats per grant).
module fifo_wr_arbiter
   import fifo_arb_pkg::*;
#(
   parameter int unsigned NUM_REQ    = NUM_REQ_DEF,
   parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
   parameter int unsigned MAX_BURST  = 4
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [NUM_REQ-1:0]            req_valid,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
   output logic [NUM_REQ-1:0]            req_ready,
   input  logic                          full,
   output logic                          wr_en,
   output logic [DATA_WIDTH-1:0]         data_in,
   output logic [$clog2(NUM_REQ)-1:0]    grant_id,
   output logic                          busy
);

   localparam int unsigned PTR_W = $clog2(NUM_REQ);

   if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_bad_num_req
      $error("NUM_REQ must be in 2..8");
   end
   if (MAX_BURST < 1 || MAX_BURST > 15) begin : g_bad_max_burst
      $error("MAX_BURST must be in 1..15");
   end

   logic                  hold_valid_q, hold_valid_d;
   logic [DATA_WIDTH-1:0] data_q, data_d;
   logic [PTR_W-1:0]      gid_q, gid_d;
   logic [PTR_W-1:0]      rr_ptr_q, rr_ptr_d;

   logic [NUM_REQ-1:0]    cand_valid;
   logic [PTR_W-1:0]      pick_idx, pick_next;
   logic                  pick_found;
   logic                  slot_free, xfer;

   rr_pick_core #(.NUM_REQ(NUM_REQ)) u_pick (
      .valid_i (cand_valid),
      .ptr_i   (rr_ptr_q),
      .idx_o   (pick_idx),
      .found_o (pick_found)
   );

   always_comb begin
      slot_free = ~hold_valid_q | ~full;
      xfer      = pick_found & slot_free & ~rst;
      req_ready = xfer ? (NUM_REQ'(1) << pick_idx) : '0;
      wr_en     = hold_valid_q & ~full & ~rst;
      pick_next = (32'(pick_idx) == NUM_REQ - 1) ? '0 : pick_idx + 1'b1;
   end

   always_comb begin
      hold_valid_d = hold_valid_q;
      data_d       = data_q;
      gid_d        = gid_q;
      if (xfer) begin
         hold_valid_d = 1'b1;
         data_d       = req_data[32'(pick_idx)*DATA_WIDTH +: DATA_WIDTH];
         gid_d        = pick_idx;
      end else if (wr_en) begin
         hold_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         hold_valid_q <= 1'b0;
         data_q       <= '0;
         gid_q        <= '0;
         rr_ptr_q     <= '0;
      end else begin
         hold_valid_q <= hold_valid_d;
         data_q       <= data_d;
         gid_q        <= gid_d;
         rr_ptr_q     <= rr_ptr_d;
      end
   end

`ifdef FIFO_ARB_BURST_EN
   arb_state_t         state_q, state_d;
   logic [PTR_W-1:0]   owner_q, owner_d, owner_next;
   logic [3:0]         cnt_q, cnt_d;
   logic [NUM_REQ-1:0] owner_mask;

   always_comb begin
      owner_mask = NUM_REQ'(1) << owner_q;
      owner_next = (32'(owner_q) == NUM_REQ - 1) ? '0 : owner_q + 1'b1;
      cand_valid = req_valid;
      if (state_q == ARB_LOCKED) begin
         cand_valid = req_valid & owner_mask;
      end
   end

   // A full stall leaves slot_free low, so neither exit condition can fire.
   always_comb begin
      state_d  = state_q;
      owner_d  = owner_q;
      cnt_d    = cnt_q;
      rr_ptr_d = rr_ptr_q;
      case (state_q)
         ARB_IDLE: begin
            if (xfer) begin
               if (MAX_BURST <= 1) begin
                  rr_ptr_d = pick_next;
               end else begin
                  state_d = ARB_LOCKED;
                  owner_d = pick_idx;
                  cnt_d   = 4'd1;
               end
            end
         end
         ARB_LOCKED: begin
            if (xfer) begin
               if (32'(cnt_q) + 1 >= MAX_BURST) begin
                  state_d  = ARB_IDLE;
                  cnt_d    = '0;
                  rr_ptr_d = owner_next;
               end else begin
                  cnt_d = cnt_q + 4'd1;
               end
            end else if (((req_valid & owner_mask) == '0) && slot_free) begin
               state_d  = ARB_IDLE;
               cnt_d    = '0;
               rr_ptr_d = owner_next;
            end
         end
         default: state_d = ARB_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ARB_IDLE;
         owner_q <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         owner_q <= owner_d;
         cnt_q   <= cnt_d;
      end
   end
`else
   always_comb begin
      cand_valid = req_valid;
      rr_ptr_d   = xfer ? pick_next : rr_ptr_q;
   end
`endif

   assign data_in  = data_q;
   assign grant_id = gid_q;
   assign busy     = hold_valid_q;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter: reset, fairness, full stall, wrap,
// mid-operation reset, and burst lock when FIFO_ARB_BURST_EN is defined.
module tb_fifo_wr_arbiter;

   logic        clk;
   logic        rst;
   logic [3:0]  req_valid;
   logic [31:0] req_data;
   logic [3:0]  req_ready;
   logic        full;
   logic        wr_en;
   logic [7:0]  data_in;
   logic [1:0]  grant_id;
   logic        busy;

   int n_checks = 0;
   int n_fail   = 0;

   logic [7:0] dexp [4] = '{8'h11, 8'h22, 8'h33, 8'h44};

   fifo_wr_arbiter #(.NUM_REQ(4), .DATA_WIDTH(8), .MAX_BURST(4)) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_data  (req_data),
      .req_ready (req_ready),
      .full      (full),
      .wr_en     (wr_en),
      .data_in   (data_in),
      .grant_id  (grant_id),
      .busy      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: run did not finish, observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(negedge clk);
   endtask

   initial begin
      rst       = 1'b1;
      full      = 1'b0;
      req_valid = 4'hF;
      req_data  = {8'h44, 8'h33, 8'h22, 8'h11};

      // Reset held 3 cycles with every requester valid
      for (int i = 0; i < 3; i++) begin
         step(); #1;
         chk("rst_ready", req_ready, 4'b0000);
         chk("rst_wr_en", wr_en, 1'b0);
         chk("rst_data", data_in, 8'h00);
         chk("rst_gid", grant_id, 2'd0);
         chk("rst_busy", busy, 1'b0);
      end

      // Fairness: all valid, full low
      step(); rst = 1'b0; #1;
      chk("fair_first_ready", req_ready, 4'b0001);
      chk("fair_first_wr_en", wr_en, 1'b0);
      for (int k = 0; k < 8; k++) begin
         step(); #1;
         chk("fair_gid", grant_id, 32'(k % 4));
         chk("fair_data", data_in, dexp[k % 4]);
         chk("fair_wr_en", wr_en, 1'b1);
         chk("fair_ready", req_ready, 32'(4'b0001 << ((k + 1) % 4)));
      end

      // Full stall on a beat 0xA5 from requester 2
      step(); req_data = {8'h44, 8'hA5, 8'h22, 8'h11}; req_valid = 4'b0100; #1;
      chk("pre_stall_gid", grant_id, 2'd0);
      chk("pre_stall_ready", req_ready, 4'b0100);
      for (int k = 0; k < 5; k++) begin
         step(); full = 1'b1; req_valid = 4'b1011; #1;
         chk("stall_wr_en", wr_en, 1'b0);
         chk("stall_data", data_in, 8'hA5);
         chk("stall_gid", grant_id, 2'd2);
         chk("stall_ready", req_ready, 4'b0000);
         chk("stall_busy", busy, 1'b1);
      end
      // Release: write and a fresh accept in the same cycle (rr_ptr=3)
      step(); full = 1'b0; req_valid = 4'b1010; #1;
      chk("release_wr_en", wr_en, 1'b1);
      chk("release_data", data_in, 8'hA5);
      chk("wrap_first_ready", req_ready, 4'b1000);

      // Wrap: 3 then 1, leaving rr_ptr=2
      step(); req_valid = 4'b0010; #1;
      chk("wrap_gid3", grant_id, 2'd3);
      chk("wrap_data3", data_in, 8'h44);
      chk("wrap_wr_en3", wr_en, 1'b1);
      chk("wrap_ready1", req_ready, 4'b0010);
      step(); req_valid = 4'b0000; #1;
      chk("wrap_gid1", grant_id, 2'd1);
      chk("wrap_data1", data_in, 8'h22);
      chk("wrap_idle_ready", req_ready, 4'b0000);
      step(); #1;
      chk("drain_busy", busy, 1'b0);
      chk("drain_wr_en", wr_en, 1'b0);
      step(); req_valid = 4'b1111; #1;
      chk("ptr_after_wrap", req_ready, 4'b0100);

      // Mid-operation reset with a held beat
      step(); full = 1'b1; req_valid = 4'b0001; #1;
      chk("mid_busy", busy, 1'b1);
      chk("mid_wr_en", wr_en, 1'b0);
      chk("mid_gid", grant_id, 2'd2);
      step(); rst = 1'b1; full = 1'b0; #1;
      chk("mid_rst_wr_en", wr_en, 1'b0);
      chk("mid_rst_ready", req_ready, 4'b0000);
      step(); rst = 1'b0; req_valid = 4'b1111; #1;
      chk("post_rst_busy", busy, 1'b0);
      chk("post_rst_wr_en", wr_en, 1'b0);
      chk("post_rst_data", data_in, 8'h00);
      chk("post_rst_ready", req_ready, 4'b0001);
      step(); #1;
      chk("post_rst_gid", grant_id, 2'd0);
      chk("post_rst_beat", data_in, 8'h11);
      chk("post_rst_wr_en2", wr_en, 1'b1);

`ifdef FIFO_ARB_BURST_EN
      // Burst lock: requesters 0 and 1 always valid
      step(); rst = 1'b1; req_valid = 4'b0011;
      step(); rst = 1'b0; #1;
      chk("burst_first_ready", req_ready, 4'b0001);
      for (int k = 0; k < 8; k++) begin
         step(); #1;
         chk("burst_gid", grant_id, (k < 4) ? 32'd0 : 32'd1);
         chk("burst_wr_en", wr_en, 1'b1);
         if (k == 3) chk("burst_switch_ready", req_ready, 4'b0010);
         if (k == 7) chk("burst_wrap_ready", req_ready, 4'b0001);
         if (k == 5) begin
            chk("burst_lock_ready", req_ready, 4'b0010);
            full = 1'b1;
            #1;
            chk("burst_stall_ready0", req_ready, 4'b0000);
            for (int s = 0; s < 2; s++) begin
               step(); #1;
               chk("burst_stall_gid", grant_id, 2'd1);
               chk("burst_stall_ready", req_ready, 4'b0000);
            end
            full = 1'b0;
            #1;
            chk("burst_resume_ready", req_ready, 4'b0010);
         end
      end
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
